// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the execute stage and the data bus.
// Runs one req/gnt/rvalid bus transaction per memory operation and stalls the PC with hold_o
// until it completes. Produces byte enables and lane-replicated store data, and returns
// sign/zero-extended load data to the register file. An optional bus timeout is set by MAX_WAIT.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// with err_o instead of issuing a bus cycle.

module mem_access_ctrl #(
  parameter int unsigned MAX_WAIT = 255  // timeout across REQ+WAIT in cycles, 0 disables it
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_re,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  byte_sel,
  input  logic        un_sign,
  input  logic [4:0]  rd_waddr,
  output logic        hold_o,
  output logic        rd_we_o,
  output logic [4:0]  rd_waddr_o,
  output logic [31:0] rd_wdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        err_o
);

  // Last counter value at which the access is still allowed to wait.
  localparam logic [31:0] WaitLast = (MAX_WAIT == 0) ? 32'd0 : MAX_WAIT - 1;
  localparam bit          TimeoutEn = (MAX_WAIT != 0);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;

  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  logic        req_any;
  logic        misalign;
  logic        timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] rdata_sh;
  logic [15:0] rdata_half;
  logic [31:0] load_ext;

  assign req_any = req_re | req_we;

  // The timeout fires once the counter reaches its limit without the bus having made progress.
  assign timeout = TimeoutEn && (cnt_q >= WaitLast);

  // Misalignment check on the incoming request; disabled builds never trap.
  always_comb begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    misalign = ((byte_sel == 2'b01) & req_addr[0]) | (byte_sel[1] & (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  // Byte enables and lane-replicated store data from the incoming request.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = req_wdata;
    unique case (byte_sel)
      2'b00: begin
        be_new    = 4'b0001 << req_addr[1:0];
        wdata_new = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_new    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{req_wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = req_wdata;
      end
    endcase
  end

  // Extract the addressed lane of the returned word and extend it to 32 bits.
  always_comb begin
    rdata_sh   = bus_rdata_i >> {addr_q[1:0], 3'b000};
    rdata_half = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    unique case (size_q)
      2'b00:   load_ext = {{24{~uns_q & rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01:   load_ext = {{16{~uns_q & rdata_half[15]}}, rdata_half};
      default: load_ext = bus_rdata_i;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; bus progress takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          state_d = misalign ? StDone : StReq;
        end
      end
      StReq: begin
        if (bus_gnt_i) begin
          state_d = we_q ? StDone : StWait;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StWait: begin
        // An rvalid coinciding with the grant was seen in StReq and is never sampled.
        if (bus_rvalid_i || timeout) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: latch the request, count wait cycles, capture load data, flag errors.
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rd_d    = rd_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 32'd0;
        err_d = 1'b0;
        if (req_any) begin
          // Store wins when both strobes are set.
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = byte_sel;
          uns_d   = un_sign;
          rd_d    = rd_waddr;
          be_d    = be_new;
          wdata_d = wdata_new;
          err_d   = misalign;
        end
      end
      StReq: begin
        cnt_d = cnt_q + 32'd1;
        if (!bus_gnt_i && timeout) begin
          err_d = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 32'd1;
        if (bus_rvalid_i) begin
          rdata_d = load_ext;
        end else if (timeout) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rd_q    <= 5'd0;
      be_q    <= 4'b0000;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM outputs; everything is forced low while reset is asserted, including the
  // combinational stall in StIdle.
  always_comb begin
    hold_o      = 1'b0;
    rd_we_o     = 1'b0;
    rd_waddr_o  = 5'd0;
    rd_wdata_o  = 32'd0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = 32'd0;
    bus_be_o    = 4'b0000;
    bus_wdata_o = 32'd0;
    err_o       = 1'b0;
    if (rst) begin
      unique case (state_q)
        StIdle: hold_o = req_any;
        StReq: begin
          hold_o      = 1'b1;
          bus_req_o   = 1'b1;
          bus_we_o    = we_q;
          bus_addr_o  = {addr_q[31:2], 2'b00};
          bus_be_o    = be_q;
          bus_wdata_o = wdata_q;
        end
        StWait: hold_o = 1'b1;
        StDone: begin
          err_o = err_q;
          if (!we_q && !err_q) begin
            rd_we_o    = (rd_q != 5'd0);
            rd_waddr_o = rd_q;
            rd_wdata_o = rdata_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (built with MAX_WAIT=4). Each transaction is expanded
// by a transaction-level model into a per-cycle timeline of inputs and expected outputs; a
// single compare process checks every cycle, and literal checks pin the headline results.

module tb_mem_access_ctrl;

  localparam int unsigned MaxWait = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_re, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  byte_sel;
  logic        un_sign;
  logic [4:0]  rd_waddr;
  logic        hold_o, rd_we_o;
  logic [4:0]  rd_waddr_o;
  logic [31:0] rd_wdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        err_o;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MAX_WAIT(MaxWait)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_re       (req_re),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .byte_sel     (byte_sel),
    .un_sign      (un_sign),
    .rd_waddr     (rd_waddr),
    .hold_o       (hold_o),
    .rd_we_o      (rd_we_o),
    .rd_waddr_o   (rd_waddr_o),
    .rd_wdata_o   (rd_wdata_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_be_o     (bus_be_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .err_o        (err_o)
  );

  typedef struct {
    logic        rst, re, we;
    logic [31:0] addr, wdata;
    logic [1:0]  sel;
    logic        uns;
    logic [4:0]  rd;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        hold, rd_we;
    logic [4:0]  rd_wa;
    logic [31:0] rd_wd;
    logic        breq, bwe;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic        err;
  } vec_t;

  vec_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          hold_cnt = 0;
  int          wb_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] last_wd;
  logic [4:0]  last_wa;
  logic [31:0] last_baddr;
  logic [3:0]  last_be;
  logic [31:0] last_bwd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    v.rst = 1'b1;
    return v;
  endfunction

  // Clear every expected output, keeping the inputs.
  function automatic vec_t no_outputs(input vec_t vi);
    vec_t v;
    v = vi;
    v.hold = 0; v.rd_we = 0; v.rd_wa = '0; v.rd_wd = '0; v.breq = 0; v.bwe = 0;
    v.baddr = '0; v.be = '0; v.bwd = '0; v.err = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; req_re = v.re; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    byte_sel = v.sel; un_sign = v.uns; rd_waddr = v.rd;
    bus_gnt_i = v.gnt; bus_rvalid_i = v.rv; bus_rdata_i = v.rdata;
    exp_q.push_back(v);
  endtask

  // Emit one cycle; at cycle index abort_at reset is pulled low instead and the access ends.
  task automatic emit(input vec_t vi, inout int n, input int abort_at, inout bit ab);
    vec_t v;
    v = vi;
    if (n == abort_at) begin
      v = no_outputs(v);
      v.rst = 1'b0;
      ab = 1'b1;
    end
    drive(v);
    n++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(blank());
  endtask

  // Transaction model: gdly = REQ cycles before gnt, rdly = WAIT cycles before rvalid.
  task automatic txn(input logic we, input logic re, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] sel, input logic uns,
                     input logic [4:0] rd, input int gdly, input int rdly,
                     input logic [31:0] rdata, input int abort_at);
    vec_t        v, hv;
    int          n, c;
    bit          ab, load, mis, err, granted;
    logic [3:0]  be;
    logic [31:0] bwd, ext, lane;
    load = !we;
    if (sel == 2'd0) begin
      be = 4'b0001 << addr[1:0]; bwd = {4{wdata[7:0]}};
      lane = rdata >> (8 * addr[1:0]);
      ext = {24'd0, lane[7:0]};
      if (!uns && lane[7]) ext = ext - 32'h100;
    end else if (sel == 2'd1) begin
      be = addr[1] ? 4'b1100 : 4'b0011; bwd = {2{wdata[15:0]}};
      lane = rdata >> (16 * addr[1]);
      ext = {16'd0, lane[15:0]};
      if (!uns && lane[15]) ext = ext - 32'h10000;
    end else begin
      be = 4'b1111; bwd = wdata; ext = rdata;
    end
    mis = 0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    mis = (sel == 2'd1 && addr[0]) || (sel[1] && addr[1:0] != 2'b00);
`endif
    n = 0; ab = 0; err = 0; granted = 0; c = 0;
    v = blank();
    v.re = re; v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel; v.uns = uns; v.rd = rd;
    v.hold = 1;
    emit(v, n, abort_at, ab);
    // Request stays asserted by execute while stalled, with the operands changing meanwhile.
    hv = blank();
    hv.re = re; hv.we = we; hv.addr = ~addr; hv.wdata = ~wdata; hv.sel = sel; hv.uns = uns;
    hv.rd = rd; hv.rdata = 32'hBAD0_BAD0;
    if (mis) err = 1;
    else begin
      for (int g = 0; !ab && g < 64; g++) begin
        v = hv;
        v.gnt = (g == gdly); v.rv = v.gnt;
        v.hold = 1; v.breq = 1; v.bwe = we; v.baddr = {addr[31:2], 2'b00}; v.be = be; v.bwd = bwd;
        emit(v, n, abort_at, ab);
        if (ab) break;
        c++;
        if (v.gnt) begin granted = 1; break; end
        if (MaxWait != 0 && c >= MaxWait) begin err = 1; break; end
      end
      if (granted && load) begin
        for (int j = 0; !ab && j < 64; j++) begin
          v = hv;
          v.rv = (j == rdly); v.rdata = v.rv ? rdata : 32'h5A5A_5A5A; v.hold = 1;
          emit(v, n, abort_at, ab);
          if (ab) break;
          c++;
          if (v.rv) break;
          if (MaxWait != 0 && c >= MaxWait) begin err = 1; break; end
        end
      end
    end
    if (!ab) begin
      v = blank();
      v.err = err;
      if (!err && load) begin
        v.rd_we = (rd != 5'd0); v.rd_wa = rd; v.rd_wd = ext;
      end
      emit(v, n, abort_at, ab);
    end
  endtask

  task automatic drain();
    wait (exp_q.size() == 0);
    #1;
  endtask

  task automatic clr_stats();
    hold_cnt = 0; wb_cnt = 0; err_cnt = 0;
    last_wd = '0; last_wa = '0; last_baddr = '0; last_be = '0; last_bwd = '0;
  endtask

  // Compare every cycle against the model timeline.
  always @(negedge clk) begin : cmp
    vec_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("hold_o", hold_o, e.hold);
      check("rd_we_o", rd_we_o, e.rd_we);
      check("rd_waddr_o", rd_waddr_o, e.rd_wa);
      check("rd_wdata_o", rd_wdata_o, e.rd_wd);
      check("bus_req_o", bus_req_o, e.breq);
      check("bus_we_o", bus_we_o, e.bwe);
      check("bus_addr_o", bus_addr_o, e.baddr);
      check("bus_be_o", bus_be_o, e.be);
      check("bus_wdata_o", bus_wdata_o, e.bwd);
      check("err_o", err_o, e.err);
      if (hold_o) hold_cnt++;
      if (err_o) err_cnt++;
      if (rd_we_o) begin wb_cnt++; last_wd = rd_wdata_o; last_wa = rd_waddr_o; end
      if (bus_req_o) begin last_baddr = bus_addr_o; last_be = bus_be_o; last_bwd = bus_wdata_o; end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req_re = 0; req_we = 0; req_addr = '0; req_wdata = '0; byte_sel = '0;
    un_sign = 0; rd_waddr = '0; bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
    clr_stats();

    // Reset with a request pending: all outputs must stay low.
    begin
      vec_t v;
      v = blank(); v.rst = 0; v.re = 1; v.addr = 32'h40;
      drive(v); drive(v);
    end
    idle(2);

    // sw 0x100
    drain(); clr_stats();
    txn(1, 0, 32'h100, 32'hDEAD_BEEF, 2'b10, 0, 5'd0, 0, 0, '0, -1);
    drain();
    check("sw_hold_cycles", hold_cnt, 2);
    check("sw_no_wb", wb_cnt, 0);
    check("sw_addr", last_baddr, 32'h100);
    check("sw_be", last_be, 4'b1111);
    check("sw_wdata", last_bwd, 32'hDEAD_BEEF);

    // sb 0x103
    clr_stats();
    txn(1, 0, 32'h103, 32'h0000_00A5, 2'b00, 0, 5'd0, 0, 0, '0, -1);
    drain();
    check("sb_be", last_be, 4'b1000);
    check("sb_wdata", last_bwd, 32'hA5A5_A5A5);

    // lb 0x102 signed and unsigned
    clr_stats();
    txn(0, 1, 32'h102, '0, 2'b00, 0, 5'd5, 0, 0, 32'h1280_FF00, -1);
    drain();
    check("lb_hold_cycles", hold_cnt, 3);
    check("lb_wb_count", wb_cnt, 1);
    check("lb_waddr", last_wa, 5'd5);
    check("lb_data", last_wd, 32'hFFFF_FF80);
    clr_stats();
    txn(0, 1, 32'h102, '0, 2'b00, 1, 5'd5, 0, 0, 32'h1280_FF00, -1);
    drain();
    check("lbu_data", last_wd, 32'h0000_0080);

    // lh 0x102 with grant held off 3 cycles
    clr_stats();
    txn(0, 1, 32'h102, '0, 2'b01, 0, 5'd9, 3, 0, 32'h8001_1234, -1);
    drain();
    check("lh_hold_cycles", hold_cnt, 6);
    check("lh_data", last_wd, 32'hFFFF_8001);

    // Load, grant never arrives: timeout after 4 waiting cycles
    clr_stats();
    txn(0, 1, 32'h300, '0, 2'b10, 0, 5'd3, 1000, 0, '0, -1);
    drain();
    check("tmo_err_pulses", err_cnt, 1);
    check("tmo_no_wb", wb_cnt, 0);
    check("tmo_hold_cycles", hold_cnt, 5);

    // Timeout in WAIT, rvalid never arrives
    txn(0, 1, 32'h304, '0, 2'b00, 1, 5'd4, 0, 1000, '0, -1);

    // Reset during WAIT, then a normal load
    txn(0, 1, 32'h200, '0, 2'b10, 0, 5'd6, 0, 5, 32'h1111_2222, 2);
    idle(1);
    clr_stats();
    txn(0, 1, 32'h204, '0, 2'b10, 0, 5'd7, 1, 1, 32'hCAFE_F00D, -1);
    drain();
    check("post_rst_wb", wb_cnt, 1);
    check("post_rst_data", last_wd, 32'hCAFE_F00D);

    // Assorted patterns: load and store both set, size 11, half store, rd 0, lane 1, misaligned
    txn(1, 1, 32'h010, 32'h1234_5678, 2'b11, 0, 5'd2, 0, 0, '0, -1);
    txn(1, 0, 32'h020, 32'hABCD_9876, 2'b01, 0, 5'd0, 2, 0, '0, -1);
    txn(0, 1, 32'h030, '0, 2'b10, 0, 5'd0, 0, 0, 32'h7777_8888, -1);
    txn(0, 1, 32'h101, '0, 2'b00, 0, 5'd1, 0, 2, 32'h0000_7F00, -1);
    txn(0, 1, 32'h102, '0, 2'b10, 0, 5'd8, 0, 0, 32'h0BAD_F00D, -1);
    txn(0, 1, 32'h001, '0, 2'b01, 1, 5'd31, 0, 0, 32'hFFFF_9ABC, -1);
    idle(2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
